mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single-ported memory shared by the instruction fetch path and the load/store path of `processor`. It accepts one request at a time from either requester, drives the memory request/acknowledge handshake, and returns read data or write completion to the owner. Priority is load/store-first, with a starvation counter that guarantees fetch progress. An optional store guard blocks writes into the instruction region.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store (load/store first,
// fetch starvation bounded). Define MEM_ARB_STORE_GUARD_EN to reject stores into the imem region.
module mem_port_arbiter #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       STARVE_MAX = 4,
  parameter logic [ADDR_W-1:0] IMEM_TOP   = ADDR_W'(32'h0000_0FFF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef MEM_ARB_STORE_GUARD_EN
  localparam bit GuardEn = 1'b1;
`else
  localparam bit GuardEn = 1'b0;
`endif
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;  // 1: load/store owns the port
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        starve_q, starve_d;
  logic              fault_q, fault_d;
  logic              if_gnt_q, if_gnt_d;
  logic              ls_gnt_q, ls_gnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic if_pend, ls_pend, pick_ls, store_blocked;

  // A requester still shows req in its grant cycle; that request is already consumed.
  assign if_pend       = if_req & ~if_gnt_q;
  assign ls_pend       = ls_req & ~ls_gnt_q;
  assign pick_ls       = ls_pend & (~if_pend | (starve_q != StarveMax));
  assign store_blocked = GuardEn & ls_we & (ls_addr <= IMEM_TOP);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;
    fault_d    = fault_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_gnt_d   = 1'b0;
    ls_gnt_d   = 1'b0;
    case (state_q)
      StBusy: begin
        if (mem_ack) begin
          state_d = StResp;
          fault_d = 1'b0;
          if (owner_q) ls_rdata_d = we_q ? '0 : mem_rdata;
          else         if_rdata_d = mem_rdata;
        end
      end
      StIdle, StResp: begin
        state_d = StIdle;
        if (pick_ls) begin
          owner_d  = 1'b1;
          we_d     = ls_we;
          addr_d   = ls_addr;
          wdata_d  = ls_wdata;
          ls_gnt_d = 1'b1;
          if (if_pend && (starve_q < StarveMax)) starve_d = starve_q + 4'd1;
          if (store_blocked) begin
            state_d    = StResp;
            fault_d    = 1'b1;
            ls_rdata_d = '0;
          end else begin
            state_d = StBusy;
            fault_d = 1'b0;
          end
        end else if (if_pend) begin
          owner_d  = 1'b0;
          we_d     = 1'b0;
          addr_d   = if_addr;
          wdata_d  = '0;
          if_gnt_d = 1'b1;
          starve_d = '0;
          fault_d  = 1'b0;
          state_d  = StBusy;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_q   <= '0;
      fault_q    <= 1'b0;
      if_gnt_q   <= 1'b0;
      ls_gnt_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      fault_q    <= fault_d;
      if_gnt_q   <= if_gnt_d;
      ls_gnt_q   <= ls_gnt_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign ls_gnt    = ls_gnt_q;
  assign if_rvalid = (state_q == StResp) & ~owner_q;
  assign ls_rvalid = (state_q == StResp) & owner_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_fault  = GuardEn & ls_rvalid & fault_q;
  assign mem_req   = (state_q == StBusy);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-level model of the arbitration rules and a behavioural memory.
module tb_mem_port_arbiter;
  localparam int unsigned SMAX = 4;
  localparam logic [31:0] ITOP = 32'h0000_0FFF;
`ifdef MEM_ARB_STORE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_fault;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX), .IMEM_TOP(ITOP)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_fault(ls_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_vec = 0, n_bad = 0;
  // requesters
  logic        if_act, if_seen, ls_act, ls_seen, ls_w;
  logic [31:0] if_a, ls_a, ls_d;
  int          if_auto, ls_auto, req_pct, wait_mode;
  // model: phase 0 = port free, 1 = memory access pending, 2 = response cycle
  int          phase, waits, starve, cyc;
  logic        m_ls, m_we, m_fault, e_if_gnt, e_ls_gnt, rst_now, just_reset;
  logic [31:0] m_addr, m_wdata, e_if_rdata, e_ls_rdata;
  logic [31:0] mem_model [logic [31:0]];
  // per-scenario observations
  int          glog[$], gcyc[$];
  int          mreq_cnt, fault_cnt, rv_cnt;
  logic [31:0] tgt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic int log_at(input int i);
    if (i < glog.size()) return glog[i];
    return -1;
  endfunction

  task automatic clear_obs();
    glog.delete(); gcyc.delete();
    mreq_cnt = 0; fault_cnt = 0; rv_cnt = 0;
  endtask

  task automatic set_if(input logic [31:0] a);
    if_act = 1'b1; if_a = a;
  endtask

  task automatic set_ls(input logic w, input logic [31:0] a, input logic [31:0] d);
    ls_act = 1'b1; ls_w = w; ls_a = a; ls_d = d;
  endtask

  task automatic step();
    logic        ack, n_if_gnt, n_ls_gnt;
    logic [31:0] rd;
    bit          if_p, ls_p;
    // compare this cycle against the model
    chk("if_gnt", if_gnt, e_if_gnt);
    chk("ls_gnt", ls_gnt, e_ls_gnt);
    chk("mem_req", mem_req, phase == 1);
    chk("if_rvalid", if_rvalid, phase == 2 && !m_ls);
    chk("ls_rvalid", ls_rvalid, phase == 2 && m_ls);
    chk("ls_fault", ls_fault, phase == 2 && m_ls && m_fault);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("ls_rdata", ls_rdata, e_ls_rdata);
    if (phase == 1) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (just_reset) begin
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      just_reset = 1'b0;
    end
    if (if_gnt) begin glog.push_back(0); gcyc.push_back(cyc); end
    if (ls_gnt) begin glog.push_back(1); gcyc.push_back(cyc); end
    if (mem_req && mem_addr == tgt) mreq_cnt++;
    if (ls_rvalid && ls_fault) fault_cnt++;
    if (if_rvalid) rv_cnt++;
    if (ls_rvalid) rv_cnt++;

    // requesters drop req after the edge that ends their grant cycle
    if (if_seen) begin if_act = 1'b0; if_seen = 1'b0; end
    if (ls_seen) begin ls_act = 1'b0; ls_seen = 1'b0; end
    if (!if_act && if_auto > 0 && int'($urandom_range(0, 99)) < req_pct) begin
      if_auto--;
      set_if(32'($urandom_range(0, 255)) << 2);
    end
    if (!ls_act && ls_auto > 0 && int'($urandom_range(0, 99)) < req_pct) begin
      ls_auto--;
      case ($urandom_range(0, 3))
        0:       ls_a = 32'h100 + (32'($urandom_range(0, 7)) << 2);
        1:       ls_a = 32'h0FFC;
        2:       ls_a = 32'h1000;
        default: ls_a = 32'h2000 + (32'($urandom_range(0, 7)) << 2);
      endcase
      set_ls(1'($urandom_range(0, 1)), ls_a, $urandom);
    end
    if_seen = e_if_gnt;
    ls_seen = e_ls_gnt;

    // memory
    ack = 1'b0;
    rd  = $urandom;
    if (phase == 1 && !rst_now) begin
      if (waits == 0) begin
        ack = 1'b1;
        if (!m_we) rd = mem_read(m_addr);
      end else waits--;
    end

    reset     = rst_now;
    if_req    = if_act;
    if_addr   = if_a;
    ls_req    = ls_act;
    ls_we     = ls_w;
    ls_addr   = ls_a;
    ls_wdata  = ls_d;
    mem_ack   = ack;
    mem_rdata = rd;

    // model: what the next cycle must look like
    n_if_gnt = 1'b0;
    n_ls_gnt = 1'b0;
    if (rst_now) begin
      phase = 0; starve = 0; waits = 0;
      m_ls = 0; m_we = 0; m_fault = 0; m_addr = 0; m_wdata = 0;
      e_if_rdata = 0; e_ls_rdata = 0;
      if_act = 0; ls_act = 0; if_seen = 0; ls_seen = 0; if_auto = 0; ls_auto = 0;
      just_reset = 1'b1;
      rst_now = 1'b0;
    end else if (phase == 1) begin
      if (ack) begin
        phase = 2;
        m_fault = 1'b0;
        if (m_we) mem_model[m_addr] = m_wdata;
        if (m_ls) e_ls_rdata = m_we ? 32'h0 : rd;
        else      e_if_rdata = rd;
      end
    end else begin
      if_p = if_act && !if_seen;
      ls_p = ls_act && !ls_seen;
      phase = 0;
      if (ls_p && (!if_p || starve < int'(SMAX))) begin
        if (if_p) starve++;
        m_ls = 1; m_we = ls_w; m_addr = ls_a; m_wdata = ls_d;
        n_ls_gnt = 1'b1;
        if (GUARD && ls_w && ls_a <= ITOP) begin
          phase = 2; m_fault = 1'b1; e_ls_rdata = 32'h0;
        end else begin
          phase = 1; m_fault = 1'b0;
          waits = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        end
      end else if (if_p) begin
        starve = 0;
        m_ls = 0; m_we = 0; m_addr = if_a; m_wdata = 0; m_fault = 0;
        n_if_gnt = 1'b1;
        phase = 1;
        waits = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
      end
    end
    e_if_gnt = n_if_gnt;
    e_ls_gnt = n_ls_gnt;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    reset = 1'b1; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    if_act = 0; if_seen = 0; ls_act = 0; ls_seen = 0; ls_w = 0;
    if_a = 0; ls_a = 0; ls_d = 0; if_auto = 0; ls_auto = 0; req_pct = 100; wait_mode = 0;
    phase = 0; waits = 0; starve = 0; cyc = 0;
    m_ls = 0; m_we = 0; m_fault = 0; m_addr = 0; m_wdata = 0;
    e_if_gnt = 0; e_ls_gnt = 0; e_if_rdata = 0; e_ls_rdata = 0;
    rst_now = 0; just_reset = 1; tgt = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;

    // lone fetch, zero-wait memory
    clear_obs();
    mem_model[32'h40] = 32'hDEADBEEF;
    set_if(32'h40);
    run(5);
    chk("s1_grants", glog.size(), 1);
    chk("s1_owner", log_at(0), 0);
    chk("s1_rdata", if_rdata, 32'hDEADBEEF);
    chk("s1_rvalids", rv_cnt, 1);

    // simultaneous fetch + load: load first, fetch straight out of the response cycle
    clear_obs();
    set_if(32'h80);
    set_ls(1'b0, 32'h2000, 32'h0);
    run(8);
    chk("s2_first", log_at(0), 1);
    chk("s2_second", log_at(1), 0);
    chk("s2_gap", (gcyc.size() == 2) ? gcyc[1] - gcyc[0] : -1, 2);

    // both held: SMAX load/store grants, one fetch, then load/store again
    clear_obs();
    if_auto = 2;
    ls_auto = SMAX + 2;
    run(30);
    for (int i = 0; i < int'(SMAX); i++) chk("s3_ls_run", log_at(i), 1);
    chk("s3_fetch", log_at(SMAX), 0);
    chk("s3_ls_after", log_at(SMAX + 1), 1);

    // load with 3 wait states, fetch arrives mid-access
    clear_obs();
    tgt = 32'h300;
    wait_mode = 3;
    set_ls(1'b0, 32'h300, 32'h0);
    run(2);
    set_if(32'h84);
    run(12);
    chk("s4_req_cycles", mreq_cnt, 4);
    chk("s4_first", log_at(0), 1);
    chk("s4_second", log_at(1), 0);
    chk("s4_grants", glog.size(), 2);
    wait_mode = 0;

    // store into the instruction region
    clear_obs();
    tgt = 32'h100;
    set_ls(1'b1, 32'h100, 32'h1234_5678);
    run(5);
    chk("s5_req_cycles", mreq_cnt, GUARD ? 0 : 1);
    chk("s5_faults", fault_cnt, GUARD ? 1 : 0);
    set_ls(1'b0, 32'h100, 32'h0);
    run(5);

    // store just above the region, then read it back
    clear_obs();
    tgt = 32'h1000;
    set_ls(1'b1, 32'h1000, 32'hCAFE_F00D);
    run(5);
    chk("s6_req_cycles", mreq_cnt, 1);
    chk("s6_faults", fault_cnt, 0);
    set_ls(1'b0, 32'h1000, 32'h0);
    run(5);
    chk("s6_readback", ls_rdata, 32'hCAFE_F00D);

    // reset in the second memory-wait cycle abandons the fetch
    clear_obs();
    wait_mode = 3;
    set_if(32'h44);
    run(2);
    rst_now = 1'b1;
    run(7);
    chk("s7_no_rvalid", rv_cnt, 0);
    wait_mode = 0;
    set_if(32'h48);
    run(4);
    chk("s7_grants", glog.size(), 2);
    chk("s7_rvalid", rv_cnt, 1);

    // random traffic
    clear_obs();
    wait_mode = -1;
    req_pct = 40;
    if_auto = 400;
    ls_auto = 400;
    run(2500);
    if_auto = 0;
    ls_auto = 0;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
